// File: rtl/pu_spi_pingpong_buffer.sv
// Double-buffered exchange between the NITTA bus and an SPI core: one ping-pong
// pair for send, one for receive, swapped on flag_cycle once SPI is idle.
module pu_spi_pingpong_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ATTR_WIDTH  = 4,
  parameter int BUFFER_SIZE = 6,
  localparam int CNT_W      = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  input  logic                  flag_cycle,
  output logic                  flag_swapped,
  output logic                  flag_error,
  input  logic                  spi_busy,
  input  logic                  spi_tx_rd,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [CNT_W-1:0]      spi_tx_count,
  output logic                  spi_tx_empty,
  input  logic                  spi_rx_wr,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  spi_rx_full,
  output logic                  dbg_state_o
);

  localparam int AW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUFFER_SIZE);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  // Handshake: every strobe is a single-cycle request sampled on the rising
  // edge; no ready exists, so a strobe that cannot be honoured is dropped and
  // recorded in flag_error. SPI strobes count only while spi_busy is high.

  logic [DATA_WIDTH-1:0] send_mem [2][BUFFER_SIZE];
  logic [DATA_WIDTH-1:0] recv_mem [2][BUFFER_SIZE];

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]      tx_ptr_q, tx_ptr_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  inv_q, inv_d;
  logic                  err_q, err_d;
  logic                  swapped_q;
  logic                  swap;
  logic                  wr_ok, rd_ok, tx_ok, rx_ok;
  logic                  tx_req, rx_req;

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flag_cycle && spi_busy) state_d = S_PENDING;
        else if (flag_cycle)        swap    = 1'b1;
      end
      S_PENDING: begin
        if (!spi_busy) begin
          swap    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_req = spi_busy && spi_tx_rd;
    rx_req = spi_busy && spi_rx_wr;
    wr_ok  = signal_wr && (wr_cnt_q < DEPTH);
    rd_ok  = signal_oe && (rd_ptr_q < rd_cnt_q);
    tx_ok  = tx_req && (tx_ptr_q < tx_cnt_q);
    rx_ok  = rx_req && (rx_cnt_q < DEPTH);

    wr_cnt_d   = wr_cnt_q + CNT_W'(wr_ok);
    rd_ptr_d   = rd_ptr_q + CNT_W'(rd_ok);
    tx_ptr_d   = tx_ptr_q + CNT_W'(tx_ok);
    rx_cnt_d   = rx_cnt_q + CNT_W'(rx_ok);
    rd_cnt_d   = rd_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    sel_d      = sel_q;
    data_out_d = data_out_q;
    inv_d      = inv_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q | (signal_wr && !wr_ok) | (signal_oe && !rd_ok)
               | (tx_req && !tx_ok) | (rx_req && !rx_ok);

    if (signal_oe) begin
      data_out_d = rd_ok ? recv_mem[sel_q][rd_ptr_q[AW-1:0]] : '0;
      inv_d      = !rd_ok;
    end
    if (tx_req) tx_data_d = tx_ok ? send_mem[!sel_q][tx_ptr_q[AW-1:0]] : '0;

    // A write landing on the swap edge is still handed to the SPI side.
    if (swap) begin
      sel_d    = !sel_q;
      tx_cnt_d = wr_cnt_d;
      wr_cnt_d = '0;
      tx_ptr_d = '0;
      rd_cnt_d = rx_cnt_d;
      rx_cnt_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      tx_cnt_q   <= '0;
      tx_ptr_q   <= '0;
      rx_cnt_q   <= '0;
      data_out_q <= '0;
      tx_data_q  <= '0;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
      swapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ptr_q   <= tx_ptr_d;
      rx_cnt_q   <= rx_cnt_d;
      data_out_q <= data_out_d;
      tx_data_q  <= tx_data_d;
      inv_q      <= inv_d;
      err_q      <= err_d;
      swapped_q  <= swap;
    end
  end

  // Bank storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) send_mem[sel_q][wr_cnt_q[AW-1:0]] <= data_in;
    if (rx_ok) recv_mem[!sel_q][rx_cnt_q[AW-1:0]] <= spi_rx_data;
  end

  assign data_out     = data_out_q;
  assign attr_out     = ATTR_WIDTH'(inv_q);
  assign flag_swapped = swapped_q;
  assign flag_error   = err_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_tx_count = tx_cnt_q;
  assign spi_tx_empty = (tx_ptr_q == tx_cnt_q);
  assign spi_rx_full  = (rx_cnt_q == DEPTH);
  assign dbg_state_o  = (state_q == S_PENDING);

endmodule

// File: tb/tb_pu_spi_pingpong_buffer.sv
// Bench for pu_spi_pingpong_buffer: directed scenarios plus random fills,
// scoreboarded through expected queues on the SPI transmit and NITTA read sides.
module tb_pu_spi_pingpong_buffer;

  localparam int DW    = 32;
  localparam int AWID  = 4;
  localparam int BS    = 6;
  localparam int CNT_W = $clog2(BS + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            signal_wr, signal_oe, flag_cycle, spi_busy, spi_tx_rd, spi_rx_wr;
  logic [DW-1:0]   data_in, spi_rx_data;
  logic [DW-1:0]   data_out, spi_tx_data;
  logic [AWID-1:0] attr_out;
  logic            flag_swapped, flag_error, spi_tx_empty, spi_rx_full, dbg_state;
  logic [CNT_W-1:0] spi_tx_count;

  logic [DW-1:0] exp_q[$];    // expected SPI transmit words
  logic [DW:0]   rd_exp_q[$]; // expected {invalid, data} on the NITTA read side

  int n_vec = 0;
  int n_err = 0;

  pu_spi_pingpong_buffer #(.DATA_WIDTH(DW), .ATTR_WIDTH(AWID), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .signal_wr(signal_wr), .data_in(data_in),
    .signal_oe(signal_oe), .data_out(data_out), .attr_out(attr_out),
    .flag_cycle(flag_cycle), .flag_swapped(flag_swapped), .flag_error(flag_error),
    .spi_busy(spi_busy), .spi_tx_rd(spi_tx_rd), .spi_tx_data(spi_tx_data),
    .spi_tx_count(spi_tx_count), .spi_tx_empty(spi_tx_empty),
    .spi_rx_wr(spi_rx_wr), .spi_rx_data(spi_rx_data), .spi_rx_full(spi_rx_full),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nitta_write(input logic [DW-1:0] d);
    signal_wr = 1'b1;
    data_in   = d;
    tick();
    signal_wr = 1'b0;
  endtask

  task automatic spi_push(input logic [DW-1:0] d);
    spi_rx_wr   = 1'b1;
    spi_rx_data = d;
    tick();
    spi_rx_wr   = 1'b0;
  endtask

  task automatic swap_now();
    flag_cycle = 1'b1;
    tick();
    flag_cycle = 1'b0;
    check("swap_pulse", 64'(flag_swapped), 64'd1);
  endtask

  task automatic tx_read();
    logic [DW-1:0] e;
    spi_tx_rd = 1'b1;
    tick();
    spi_tx_rd = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL tx_queue: got empty expected entry");
    end else begin
      e = exp_q.pop_front();
      check("tx_data", 64'(spi_tx_data), 64'(e));
    end
  endtask

  task automatic nitta_read();
    logic [DW:0] e;
    signal_oe = 1'b1;
    tick();
    signal_oe = 1'b0;
    if (rd_exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL rd_queue: got empty expected entry");
    end else begin
      e = rd_exp_q.pop_front();
      check("rd_data", 64'(data_out), 64'(e[DW-1:0]));
      check("rd_attr", 64'(attr_out), 64'(e[DW]));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    check("rst_tx_count", 64'(spi_tx_count), 64'd0);
    check("rst_tx_empty", 64'(spi_tx_empty), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_error", 64'(flag_error), 64'd0);
    check("rst_rx_full", 64'(spi_rx_full), 64'd0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w;
    int n;
    signal_wr = 0; signal_oe = 0; flag_cycle = 0; spi_busy = 0;
    spi_tx_rd = 0; spi_rx_wr = 0; data_in = '0; spi_rx_data = '0;
    rst = 1'b0;
    tick();
    apply_reset();
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_attr", 64'(attr_out), 64'd0);
    check("rst_swapped", 64'(flag_swapped), 64'd0);
    check("rst_tx_data", 64'(spi_tx_data), 64'd0);

    // NITTA writes 1,2 then hands them to SPI
    nitta_write(32'd1);
    nitta_write(32'd2);
    swap_now();
    check("tx_count_2", 64'(spi_tx_count), 64'd2);
    check("tx_not_empty", 64'(spi_tx_empty), 64'd0);
    tick();
    check("swap_once", 64'(flag_swapped), 64'd0);
    spi_busy = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    tx_read(); tx_read();
    check("tx_drained", 64'(spi_tx_empty), 64'd1);
    check("no_err_yet", 64'(flag_error), 64'd0);
    tx_read();
    check("tx_underflow_err", 64'(flag_error), 64'd1);

    // SPI receives 7,8; NITTA reads them after the swap
    spi_push(32'd7); spi_push(32'd8);
    spi_busy = 1'b0;
    swap_now();
    check("tx_count_0", 64'(spi_tx_count), 64'd0);
    rd_exp_q.push_back({1'b0, 32'd7});
    rd_exp_q.push_back({1'b0, 32'd8});
    rd_exp_q.push_back({1'b1, 32'd0});
    nitta_read(); nitta_read(); nitta_read();

    // Overflowing the send bank
    apply_reset();
    for (int i = 0; i < BS; i++) begin
      w = $urandom;
      exp_q.push_back(w);
      nitta_write(w);
    end
    check("full_no_err", 64'(flag_error), 64'd0);
    nitta_write(32'hdead_beef);
    check("wr_overflow_err", 64'(flag_error), 64'd1);
    swap_now();
    check("tx_count_full", 64'(spi_tx_count), 64'(BS));
    spi_busy = 1'b1;
    exp_q.push_back(32'd0);
    for (int i = 0; i <= BS; i++) tx_read();

    // Swap requested while busy is deferred until busy falls
    flag_cycle = 1'b1;
    tick();
    flag_cycle = 1'b0;
    check("deferred_no_swap", 64'(flag_swapped), 64'd0);
    check("pending_state", 64'(dbg_state), 64'd1);
    for (int i = 0; i < BS; i++) begin
      w = $urandom;
      rd_exp_q.push_back({1'b0, w});
      spi_push(w);
      check("busy_no_swap", 64'(flag_swapped), 64'd0);
    end
    check("rx_full", 64'(spi_rx_full), 64'd1);
    flag_cycle = 1'b1;
    spi_push(32'h1234_5678);
    flag_cycle = 1'b0;
    check("rx_full_hold", 64'(spi_rx_full), 64'd1);
    check("still_pending", 64'(dbg_state), 64'd1);
    spi_busy = 1'b0;
    tick();
    check("deferred_swap", 64'(flag_swapped), 64'd1);
    check("tx_count_empty", 64'(spi_tx_count), 64'd0);
    tick();
    check("single_pulse", 64'(flag_swapped), 64'd0);
    check("back_idle", 64'(dbg_state), 64'd0);
    rd_exp_q.push_back({1'b1, 32'd0});
    for (int i = 0; i <= BS; i++) nitta_read();

    // Write on the swap edge is carried across
    signal_wr = 1'b1; data_in = 32'd9; flag_cycle = 1'b1;
    tick();
    signal_wr = 1'b0; flag_cycle = 1'b0;
    check("edge_swap", 64'(flag_swapped), 64'd1);
    check("edge_tx_count", 64'(spi_tx_count), 64'd1);
    spi_busy = 1'b1;
    exp_q.push_back(32'd9);
    tx_read();
    spi_busy = 1'b0;
    nitta_write(32'd5);
    swap_now();
    check("new_bank_count", 64'(spi_tx_count), 64'd1);
    spi_busy = 1'b1;
    exp_q.push_back(32'd5);
    tx_read();

    // Reset while PENDING with partial fills
    spi_busy = 1'b0;
    nitta_write(32'd11); nitta_write(32'd12); nitta_write(32'd13);
    spi_busy = 1'b1;
    flag_cycle = 1'b1;
    tick();
    flag_cycle = 1'b0;
    check("pend_before_rst", 64'(dbg_state), 64'd1);
    spi_push(32'd21); spi_push(32'd22);
    spi_busy = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_swap_after_rst", 64'(flag_swapped), 64'd0);
    end
    check("rst_count_hold", 64'(spi_tx_count), 64'd0);

    // Random fills of the send path
    for (int r = 0; r < 4; r++) begin
      spi_busy = 1'b0;
      n = $urandom_range(1, BS);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        exp_q.push_back(w);
        nitta_write(w);
      end
      swap_now();
      check("rand_tx_count", 64'(spi_tx_count), 64'(n));
      spi_busy = 1'b1;
      exp_q.push_back(32'd0);
      for (int i = 0; i <= n; i++) tx_read();
    end
    spi_busy = 1'b0;

    check("tx_queue_drained", 64'(exp_q.size()), 64'd0);
    check("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pu_spi_pingpong_buffer.md
# pu_spi_pingpong_buffer

Double-buffered exchange buffer between the NITTA data bus and an SPI transceiver core. It replaces the single shared SPI buffer with two independent ping-pong pairs: one for send (NITTA→SPI) and one for receive (SPI→NITTA). Depth and width are parametrised. On each `flag_cycle` the pairs swap roles, so NITTA never sees data being shifted mid-cycle. A swap requested while an SPI transfer is running is deferred until the transfer ends.

## Interface
- `DATA_WIDTH`, 32: word width on both sides.
- `ATTR_WIDTH`, 4: width of NITTA attribute bus.
- `BUFFER_SIZE`, 6: words per bank (≥1). `CNT_W = $clog2(BUFFER_SIZE+1)`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `signal_wr`  in  1  NITTA writes `data_in` to the send bank this cycle.
- `data_in`  in  DATA_WIDTH  NITTA write data.
- `signal_oe`  in  1  NITTA reads the next word from the receive bank this cycle.
- `data_out`  out  DATA_WIDTH  registered NITTA read data.
- `attr_out`  out  ATTR_WIDTH  bit 0 = INVALID (read past fill level); other bits 0.
- `flag_cycle`  in  1  end of computational cycle; swap request.
- `flag_swapped`  out  1  one-cycle pulse on the swap edge.
- `flag_error`  out  1  sticky: write overflow or read underflow on either side.
- `spi_busy`  in  1  SPI transfer in progress; gates SPI accesses and blocks swap.
- `spi_tx_rd`  in  1  SPI pops one word from the transmit bank.
- `spi_tx_data`  out  DATA_WIDTH  registered transmit word.
- `spi_tx_count`  out  CNT_W  words handed over at the last swap.
- `spi_tx_empty`  out  1  transmit read pointer == `spi_tx_count`.
- `spi_rx_wr`  in  1  SPI pushes `spi_rx_data` into the receive bank.
- `spi_rx_data`  in  DATA_WIDTH  received word.
- `spi_rx_full`  out  1  receive bank holds BUFFER_SIZE words.

## Operation
- Four banks: `send[0/1]`, `recv[0/1]`. A one-bit `sel` picks the NITTA-side bank of each pair; the SPI side uses `!sel`.
- NITTA write: at each edge with `signal_wr`=1 and `wr_cnt < BUFFER_SIZE`, store the word at `send[sel][wr_cnt]` and increment `wr_cnt`. If the bank is full, drop the word and set `flag_error`.
- NITTA read: at each edge with `signal_oe`=1:
  - If `rd_ptr < rd_cnt`: `data_out <= recv[sel][rd_ptr]`, `attr_out <= 0`, increment `rd_ptr`.
  - Otherwise: `data_out <= 0`, `attr_out[0] <= 1`, set `flag_error`.
- When both `signal_wr` and `signal_oe` are high in one cycle, both are performed.
- Holding a strobe for N cycles performs N accesses. There is no edge detection.
- SPI accesses are honoured only while `spi_busy`=1; otherwise they are ignored.
  - `spi_tx_rd` follows the same rules as the NITTA read, on `send[!sel]` against `spi_tx_count`. Underflow gives data 0 and sets `flag_error`.
  - `spi_rx_wr` follows the same rules as the NITTA write, into `recv[!sel]`. Overflow drops the word and sets `flag_error`.
- Swap state machine, states IDLE and PENDING:
  - IDLE→PENDING on `flag_cycle` && `spi_busy`.
  - The swap edge is any edge with (`flag_cycle` || PENDING) && !`spi_busy`. It returns to IDLE.
- At the swap edge:
  - `sel` toggles and `flag_swapped` pulses.
  - `spi_tx_count <= wr_cnt`, including a NITTA write on this same edge. `wr_cnt <= 0`; the SPI transmit pointer resets to 0.
  - `rd_cnt <= rx_cnt`; `rx_cnt <= 0`; `rd_ptr <= 0`.
- A NITTA read on the swap edge uses the pre-swap bank.
- A `flag_cycle` while already PENDING has no extra effect: there is one swap.
- `flag_error` clears only on reset.

## Timing
- Reset values:
  - All outputs 0, except `spi_tx_empty`=1 (count 0 == pointer 0).
  - `sel`=0, state IDLE, all counters and pointers 0.
  - Bank contents are not reset.
- Read latency: 1 cycle. `data_out`/`spi_tx_data` are valid after the edge that sampled the strobe and hold until the next read.
- Write-to-visibility: a word written in cycle k is readable by the other side only after the next swap.
- Deferred swap: occurs on the first edge where `spi_busy`=0, 1 cycle after `spi_busy` falls at the earliest.
- Reset asserted mid-transfer or while PENDING returns everything to reset values immediately (asynchronously).

## Test plan
- Reset, then `signal_wr` for 2 cycles with 1, 2; pulse `flag_cycle` (busy=0) → `flag_swapped` pulses, `spi_tx_count`=2. Busy=1 with 3 `spi_tx_rd` → `spi_tx_data` = 1, 2, then 0 with `flag_error`=1.
- Busy=1, `spi_rx_wr` 7, 8; swap; `signal_oe` 3 cycles → `data_out` 7, 8, then 0 with `attr_out[0]`=1.
- Write 7 words with BUFFER_SIZE=6 → 7th dropped, `flag_error`=1; after swap `spi_tx_count`=6.
- `flag_cycle` with busy=1 → no swap and `sel` unchanged. Busy held 5 cycles, then drops → exactly one `flag_swapped` pulse, 1 cycle after the fall.
- `signal_wr`(9) on the same edge as `flag_cycle` → `spi_tx_count` includes 9, and the new NITTA bank count is 0.
- `rst`=0 while PENDING with a partial fill → all counters 0, `spi_tx_empty`=1, no swap pulse after release.
